// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU fetch/data request ports and the single-port RAM port
// that mem_arbiter multiplexes between them.
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              ireq;
  logic [31:0]       iaddr;
  logic              iack;
  logic [31:0]       irdata;
  logic              dreq;
  logic [3:0]        dwe;
  logic [31:0]       daddr;
  logic [31:0]       dwdata;
  logic              dack;
  logic [31:0]       drdata;
  logic              busy;
  logic              mem_ce;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mem_dout,
    output iack, irdata, dack, drdata, busy, mem_ce, mem_we, mem_addr, mem_din
  );

  modport master (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mem_dout,
    input  iack, irdata, dack, drdata, busy, mem_ce, mem_we, mem_addr, mem_din
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one synchronous word RAM between the
// instruction-fetch and data ports; ISSUE/WAIT/RESP per access, all outputs registered.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_last_d;   // last granted port (1 = D); also the port being served
  logic   r_wr;       // served access is a D-port write

  logic   w_ipend;
  logic   w_dpend;
  logic   w_arb;
  logic   w_grant;
  logic   w_pick_d;
  logic   w_unused;

  // In RESP the port being acked still shows its old req, so mask it out.
  always_comb begin
    w_arb    = (r_state == S_IDLE) || (r_state == S_RESP);
    w_ipend  = bus.ireq && !((r_state == S_RESP) && !r_last_d);
    w_dpend  = bus.dreq && !((r_state == S_RESP) &&  r_last_d);
    w_grant  = w_arb && (w_ipend || w_dpend);
    w_pick_d = w_dpend && (!w_ipend || !r_last_d);
  end

  assign w_unused = ^{bus.iaddr[1:0], bus.iaddr[31:ADDR_W+2],
                      bus.daddr[1:0], bus.daddr[31:ADDR_W+2]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_d     <= 1'b0;
      r_wr         <= 1'b0;
      bus.iack     <= 1'b0;
      bus.dack     <= 1'b0;
      bus.irdata   <= '0;
      bus.drdata   <= '0;
      bus.busy     <= 1'b0;
      bus.mem_ce   <= 1'b0;
      bus.mem_we   <= '0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
    end else begin
      bus.iack   <= 1'b0;
      bus.dack   <= 1'b0;
      bus.mem_ce <= 1'b0;
      bus.mem_we <= '0;

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_grant) begin
            r_state    <= S_ISSUE;
            bus.busy   <= 1'b1;
            r_last_d   <= w_pick_d;
            r_wr       <= w_pick_d && (|bus.dwe);
            bus.mem_ce <= 1'b1;
            if (w_pick_d) begin
              bus.mem_we   <= bus.dwe;
              bus.mem_addr <= bus.daddr[ADDR_W+1:2];
              bus.mem_din  <= bus.dwdata;
            end else begin
              bus.mem_addr <= bus.iaddr[ADDR_W+1:2];
              bus.mem_din  <= '0;
            end
          end else begin
            r_state  <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end

        S_ISSUE: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_state <= S_RESP;
          if (r_last_d) begin
            if (!r_wr) begin
              bus.drdata <= bus.mem_dout;
            end
            bus.dack <= 1'b1;
          end else begin
            bus.irdata <= bus.mem_dout;
            bus.iack   <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural
// byte-writable synchronous RAM, with hand-computed expected values.
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W = 16;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [31:0] ram [0:255];

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first RAM with byte lanes; data valid the cycle after mem_ce.
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      bus.mem_dout <= ram[bus.mem_addr[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) ram[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_din[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int last;
    int nacks;
    logic exp_d;

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'h2402_0005;
    ram[8'h11] = 32'h3C01_1234;
    ram[8'h20] = 32'h1122_3344;
    bus.mem_dout = '0;
    bus.ireq = 0; bus.iaddr = 0; bus.dreq = 0; bus.dwe = 0; bus.daddr = 0; bus.dwdata = 0;

    // Reset state
    do_reset();
    check("rst_busy",   {31'b0, bus.busy},   32'h0);
    check("rst_acks",   {30'b0, bus.iack, bus.dack}, 32'h0);
    check("rst_irdata", bus.irdata, 32'h0);
    check("rst_drdata", bus.drdata, 32'h0);
    check("rst_ce_we",  {27'b0, bus.mem_ce, bus.mem_we}, 32'h0);
    check("rst_addr",   {16'b0, bus.mem_addr}, 32'h0);
    check("rst_din",    bus.mem_din, 32'h0);

    // I read alone; iaddr changed after grant must not matter
    bus.ireq = 1; bus.iaddr = 32'h40;
    tick();
    check("i_c1_ce",   {31'b0, bus.mem_ce}, 32'h1);
    check("i_c1_addr", {16'b0, bus.mem_addr}, 32'h10);
    check("i_c1_we",   {28'b0, bus.mem_we}, 32'h0);
    check("i_c1_busy", {31'b0, bus.busy}, 32'h1);
    bus.iaddr = 32'h998;
    tick();
    check("i_c2_ce",   {31'b0, bus.mem_ce}, 32'h0);
    check("i_c2_iack", {31'b0, bus.iack}, 32'h0);
    tick();
    check("i_c3_iack",   {31'b0, bus.iack}, 32'h1);
    check("i_c3_irdata", bus.irdata, 32'h2402_0005);
    check("i_c3_dack",   {31'b0, bus.dack}, 32'h0);
    bus.ireq = 0;
    tick();
    check("i_c4_iack", {31'b0, bus.iack}, 32'h0);
    check("i_c4_busy", {31'b0, bus.busy}, 32'h0);

    // D byte write to lane 1, then read back
    bus.dreq = 1; bus.dwe = 4'b0010; bus.daddr = 32'h80; bus.dwdata = 32'h0000_AB00;
    tick();
    check("dw_c1_we",   {28'b0, bus.mem_we}, 32'h2);
    check("dw_c1_addr", {16'b0, bus.mem_addr}, 32'h20);
    check("dw_c1_din",  bus.mem_din, 32'h0000_AB00);
    tick();
    tick();
    check("dw_c3_dack",   {31'b0, bus.dack}, 32'h1);
    check("dw_c3_drdata", bus.drdata, 32'h0);
    bus.dreq = 0; bus.dwe = 0;
    tick();
    bus.dreq = 1; bus.daddr = 32'h80;
    tick();
    check("dr_c1_we", {28'b0, bus.mem_we}, 32'h0);
    tick();
    tick();
    check("dr_c3_dack",   {31'b0, bus.dack}, 32'h1);
    check("dr_c3_drdata", bus.drdata, 32'h1122_AB44);
    bus.dreq = 0;
    tick();

    // Tie from reset: D first, then I
    do_reset();
    bus.ireq = 1; bus.iaddr = 32'h44; bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h80;
    tick();
    check("tie_c1_addr", {16'b0, bus.mem_addr}, 32'h20);
    tick();
    check("tie_c2_ce", {31'b0, bus.mem_ce}, 32'h0);
    tick();
    check("tie_c3_acks",  {30'b0, bus.iack, bus.dack}, 32'h1);
    check("tie_c3_ce",    {31'b0, bus.mem_ce}, 32'h0);
    check("tie_c3_drdata", bus.drdata, 32'h1122_AB44);
    bus.dreq = 0;
    tick();
    check("tie_c4_ce",   {31'b0, bus.mem_ce}, 32'h1);
    check("tie_c4_addr", {16'b0, bus.mem_addr}, 32'h11);
    tick();
    check("tie_c5_ce", {31'b0, bus.mem_ce}, 32'h0);
    tick();
    check("tie_c6_acks",   {30'b0, bus.iack, bus.dack}, 32'h2);
    check("tie_c6_irdata", bus.irdata, 32'h3C01_1234);
    bus.ireq = 0;
    tick();

    // Fairness: both ports pending continuously, last grant was I
    bus.ireq = 1; bus.iaddr = 32'h40; bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h80;
    cyc = 0; last = 0; nacks = 0; exp_d = 1'b1;
    while (nacks < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.iack || bus.dack) begin
        check("fair_port", {30'b0, bus.iack, bus.dack}, exp_d ? 32'h1 : 32'h2);
        if (nacks == 0) check("fair_first", cyc, 32'd3);
        else            check("fair_gap", cyc - last, 32'd3);
        last  = cyc;
        nacks++;
        exp_d = !exp_d;
        if (nacks == 8) begin
          bus.ireq = 0;
          bus.dreq = 0;
        end
      end
    end
    if (nacks < 8) check("fair_timeout", nacks, 32'd8);
    bus.ireq = 0; bus.dreq = 0;
    tick();

    // Reset during WAIT of an I read
    bus.ireq = 1; bus.iaddr = 32'h40;
    tick();
    tick();
    rst_n = 0; bus.ireq = 0;
    tick();
    check("rmid_iack",   {31'b0, bus.iack}, 32'h0);
    check("rmid_busy",   {31'b0, bus.busy}, 32'h0);
    check("rmid_irdata", bus.irdata, 32'h0);
    check("rmid_drdata", bus.drdata, 32'h0);
    check("rmid_mem",    {bus.mem_ce, bus.mem_we, 11'b0, bus.mem_addr} | bus.mem_din, 32'h0);
    rst_n = 1;
    tick();
    check("rmid_noack", {30'b0, bus.iack, bus.dack}, 32'h0);
    bus.dreq = 1; bus.daddr = 32'h80; bus.dwe = 0;
    tick();
    tick();
    check("rmid_c2_dack", {31'b0, bus.dack}, 32'h0);
    tick();
    check("rmid_c3_dack",   {31'b0, bus.dack}, 32'h1);
    check("rmid_c3_drdata", bus.drdata, 32'h1122_AB44);
    bus.dreq = 0;
    tick();

    // Same-port back-to-back: stale req in RESP ignored
    bus.ireq = 1; bus.iaddr = 32'h40;
    tick();
    tick();
    tick();
    check("b2b_c3_iack",   {31'b0, bus.iack}, 32'h1);
    check("b2b_c3_irdata", bus.irdata, 32'h2402_0005);
    bus.iaddr = 32'h44;
    tick();
    check("b2b_c4_busy", {31'b0, bus.busy}, 32'h0);
    check("b2b_c4_ce",   {31'b0, bus.mem_ce}, 32'h0);
    tick();
    check("b2b_c5_ce",   {31'b0, bus.mem_ce}, 32'h1);
    check("b2b_c5_addr", {16'b0, bus.mem_addr}, 32'h11);
    tick();
    check("b2b_c6_iack", {31'b0, bus.iack}, 32'h0);
    tick();
    check("b2b_c7_iack",   {31'b0, bus.iack}, 32'h1);
    check("b2b_c7_irdata", bus.irdata, 32'h3C01_1234);
    bus.ireq = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
